// File: rtl/dmem_port_arbiter_if.sv
// Request/response bundle between the core LSU, the network endpoint, the local
// DMEM macro and the DMEM port arbiter.
interface dmem_port_arbiter_if #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 10
);
  localparam int mask_width_lp = data_width_p / 8;

  logic                     core_v_i;
  logic                     core_w_i;
  logic [addr_width_p-1:0]  core_addr_i;
  logic [data_width_p-1:0]  core_data_i;
  logic [mask_width_lp-1:0] core_mask_i;
  logic                     core_reserve_i;
  logic                     core_yumi_o;
  logic                     core_rdata_v_o;
  logic [data_width_p-1:0]  core_rdata_o;

  logic                     net_v_i;
  logic                     net_w_i;
  logic [addr_width_p-1:0]  net_addr_i;
  logic [data_width_p-1:0]  net_data_i;
  logic [mask_width_lp-1:0] net_mask_i;
  logic                     net_yumi_o;
  logic                     net_rdata_v_o;
  logic [data_width_p-1:0]  net_rdata_o;

  logic                     dmem_v_o;
  logic                     dmem_w_o;
  logic [addr_width_p-1:0]  dmem_addr_o;
  logic [data_width_p-1:0]  dmem_data_o;
  logic [mask_width_lp-1:0] dmem_mask_o;
  logic [data_width_p-1:0]  dmem_data_i;

  logic                     reserved_o;
  logic [addr_width_p-1:0]  reserved_addr_o;
  logic                     reserve_break_o;

  modport slave (
    input  core_v_i, core_w_i, core_addr_i, core_data_i, core_mask_i, core_reserve_i,
    output core_yumi_o, core_rdata_v_o, core_rdata_o,
    input  net_v_i, net_w_i, net_addr_i, net_data_i, net_mask_i,
    output net_yumi_o, net_rdata_v_o, net_rdata_o,
    output dmem_v_o, dmem_w_o, dmem_addr_o, dmem_data_o, dmem_mask_o,
    input  dmem_data_i,
    output reserved_o, reserved_addr_o, reserve_break_o
  );

  modport master (
    output core_v_i, core_w_i, core_addr_i, core_data_i, core_mask_i, core_reserve_i,
    input  core_yumi_o, core_rdata_v_o, core_rdata_o,
    output net_v_i, net_w_i, net_addr_i, net_data_i, net_mask_i,
    input  net_yumi_o, net_rdata_v_o, net_rdata_o,
    input  dmem_v_o, dmem_w_o, dmem_addr_o, dmem_data_o, dmem_mask_o,
    output dmem_data_i,
    input  reserved_o, reserved_addr_o, reserve_break_o
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port DMEM arbiter: core-priority grant with network anti-starvation,
// fixed one-cycle read return routing, and the tile's single LR reservation.
module dmem_port_arbiter #(
  parameter int data_width_p   = 32,
  parameter int dmem_size_p    = 1024,
  parameter int starve_limit_p = 4
) (
  input logic           clk_i,
  input logic           reset_n_i,
  dmem_port_arbiter_if.slave bus
);
  localparam int dmem_addr_width_lp = $clog2(dmem_size_p);
  localparam int mask_width_lp      = data_width_p / 8;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CORE = 2'd1,
    OWNER_NET  = 2'd2
  } owner_e;

  logic [3:0]                    starve_cnt_r, starve_cnt_n;
  owner_e                        rd_owner_r, rd_owner_n;
  logic                          reserved_r, reserved_n;
  logic [dmem_addr_width_lp-1:0] reserved_addr_r, reserved_addr_n;
  logic                          break_r, break_n;

  logic                          force_net, core_grant, net_grant;
  logic                          dmem_v, dmem_w;
  logic [dmem_addr_width_lp-1:0] dmem_addr;
  logic [data_width_p-1:0]       dmem_data;
  logic [mask_width_lp-1:0]      dmem_mask;

  // Grants look only at request valids and registered state, so neither yumi
  // can combinationally depend on the other.
  assign force_net  = (starve_cnt_r >= 4'(starve_limit_p));
  assign core_grant = bus.core_v_i & ~force_net;
  assign net_grant  = bus.net_v_i & (~bus.core_v_i | force_net);
  assign dmem_v     = core_grant | net_grant;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dmem_w    = 1'b0;
    dmem_addr = '0;
    dmem_data = '0;
    dmem_mask = '0;
    if (core_grant) begin
      dmem_w    = bus.core_w_i;
      dmem_addr = bus.core_addr_i;
      dmem_data = bus.core_data_i;
      dmem_mask = bus.core_mask_i;
    end else if (net_grant) begin
      dmem_w    = bus.net_w_i;
      dmem_addr = bus.net_addr_i;
      dmem_data = bus.net_data_i;
      dmem_mask = bus.net_mask_i;
    end
  end

  always_comb begin
    starve_cnt_n    = starve_cnt_r;
    rd_owner_n      = OWNER_NONE;
    reserved_n      = reserved_r;
    reserved_addr_n = reserved_addr_r;
    break_n         = 1'b0;

    if (net_grant)
      starve_cnt_n = '0;
    else if (bus.net_v_i && starve_cnt_r != 4'hF)
      starve_cnt_n = starve_cnt_r + 4'd1;

    if (core_grant && !bus.core_w_i)
      rd_owner_n = OWNER_CORE;
    else if (net_grant && !bus.net_w_i)
      rd_owner_n = OWNER_NET;

    // Any granted store to the reserved word breaks it, whatever its byte mask.
    break_n = dmem_v && dmem_w && reserved_r && (dmem_addr == reserved_addr_r);

    if (core_grant && !bus.core_w_i && bus.core_reserve_i) begin
      reserved_n      = 1'b1;
      reserved_addr_n = bus.core_addr_i;
    end else if (break_n) begin
      reserved_n = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt_r    <= '0;
      rd_owner_r      <= OWNER_NONE;
      reserved_r      <= 1'b0;
      reserved_addr_r <= '0;
      break_r         <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all of them sample
      // the same pre-edge values.
      starve_cnt_r    <= starve_cnt_n;
      rd_owner_r      <= rd_owner_n;
      reserved_r      <= reserved_n;
      reserved_addr_r <= reserved_addr_n;
      break_r         <= break_n;
    end
  end

  assign bus.core_yumi_o     = core_grant;
  assign bus.net_yumi_o      = net_grant;
  assign bus.dmem_v_o        = dmem_v;
  assign bus.dmem_w_o        = dmem_w;
  assign bus.dmem_addr_o     = dmem_addr;
  assign bus.dmem_data_o     = dmem_data;
  assign bus.dmem_mask_o     = dmem_mask;

  assign bus.core_rdata_v_o  = (rd_owner_r == OWNER_CORE);
  assign bus.core_rdata_o    = (rd_owner_r == OWNER_CORE) ? bus.dmem_data_i : '0;
  assign bus.net_rdata_v_o   = (rd_owner_r == OWNER_NET);
  assign bus.net_rdata_o     = (rd_owner_r == OWNER_NET) ? bus.dmem_data_i : '0;

  assign bus.reserved_o      = reserved_r;
  assign bus.reserved_addr_o = reserved_addr_r;
  assign bus.reserve_break_o = break_r;

  a_one_grant: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(core_grant && net_grant));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed stimulus pushes expected read
// responses; a negedge monitor pops and compares whenever rdata_v is seen.
module tb_dmem_port_arbiter;
  localparam int aw_lp = 10;

  typedef struct packed {
    logic        is_net;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  logic [31:0] mem [0:1023];

  dmem_port_arbiter_if #(.data_width_p(32), .addr_width_p(aw_lp)) bus ();

  dmem_port_arbiter #(
    .data_width_p(32), .dmem_size_p(1024), .starve_limit_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMEM model: preload on reset, masked writes, one-cycle read latency.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
      mem[10'h010] <= 32'hDEADBEEF;
      bus.dmem_data_i <= '0;
    end else if (bus.dmem_v_o) begin
      if (bus.dmem_w_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.dmem_mask_o[b]) mem[bus.dmem_addr_o][8*b +: 8] <= bus.dmem_data_o[8*b +: 8];
      end else begin
        bus.dmem_data_i <= mem[bus.dmem_addr_o];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input logic is_net, input logic [31:0] data);
    rsp_t r;
    r.is_net = is_net;
    r.data   = data;
    exp_q.push_back(r);
  endtask

  // Monitor: every read response presented by the DUT is matched to the queue.
  always @(negedge clk) begin
    if (rst_n && (bus.core_rdata_v_o || bus.net_rdata_v_o)) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {bus.core_rdata_v_o, bus.net_rdata_v_o}, 32'd0);
      end else begin
        rsp_t r;
        r = exp_q.pop_front();
        check("rsp_core_v", bus.core_rdata_v_o, !r.is_net);
        check("rsp_net_v", bus.net_rdata_v_o, r.is_net);
        check("rsp_data", r.is_net ? bus.net_rdata_o : bus.core_rdata_o, r.data);
        check("rsp_other_zero", r.is_net ? bus.core_rdata_o : bus.net_rdata_o, 32'd0);
      end
    end
  end

  task automatic idle();
    bus.core_v_i = 0; bus.core_w_i = 0; bus.core_addr_i = '0; bus.core_data_i = '0;
    bus.core_mask_i = '0; bus.core_reserve_i = 0;
    bus.net_v_i = 0; bus.net_w_i = 0; bus.net_addr_i = '0; bus.net_data_i = '0;
    bus.net_mask_i = '0;
  endtask

  task automatic core_req(input logic w, input logic [9:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic reserve);
    bus.core_v_i = 1; bus.core_w_i = w; bus.core_addr_i = addr;
    bus.core_data_i = data; bus.core_mask_i = mask; bus.core_reserve_i = reserve;
  endtask

  task automatic net_req(input logic w, input logic [9:0] addr, input logic [31:0] data,
                         input logic [3:0] mask);
    bus.net_v_i = 1; bus.net_w_i = w; bus.net_addr_i = addr;
    bus.net_data_i = data; bus.net_mask_i = mask;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 0;
    #1;
    check("rst_core_yumi", bus.core_yumi_o, 0);
    check("rst_dmem_v", bus.dmem_v_o, 0);
    check("rst_reserved", bus.reserved_o, 0);
    check("rst_rdata_v", {bus.core_rdata_v_o, bus.net_rdata_v_o}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Core-only load returns DEADBEEF one cycle later.
    next_cycle(); core_req(0, 10'h010, 0, 0, 0); expect_rsp(0, 32'hDEADBEEF);
    sample();
    check("t1_core_yumi", bus.core_yumi_o, 1);
    check("t1_net_yumi", bus.net_yumi_o, 0);
    check("t1_dmem_v", bus.dmem_v_o, 1);
    check("t1_dmem_addr", bus.dmem_addr_o, 32'h010);
    check("t1_dmem_w", bus.dmem_w_o, 0);
    next_cycle(); sample();
    check("t1_idle_dmem_v", bus.dmem_v_o, 0);
    check("t1_idle_dmem_addr", bus.dmem_addr_o, 0);
    check("t1_core_rdata_v", bus.core_rdata_v_o, 1);

    // Both continuously valid: one net grant in every five cycles.
    for (int i = 0; i < 10; i++) begin
      logic exp_net;
      next_cycle();
      core_req(0, 10'h011, 0, 0, 0);
      net_req(0, 10'h012, 0, 0);
      exp_net = (i % 5 == 4);
      if (exp_net) expect_rsp(1, 32'hC0DE0012);
      else         expect_rsp(0, 32'hC0DE0011);
      sample();
      check($sformatf("t2_core_yumi_%0d", i), bus.core_yumi_o, !exp_net);
      check($sformatf("t2_net_yumi_%0d", i), bus.net_yumi_o, exp_net);
    end

    // Net load, then core masked store while the net response returns.
    next_cycle(); net_req(0, 10'h012, 0, 0); expect_rsp(1, 32'hC0DE0012);
    sample();
    check("t3_net_yumi", bus.net_yumi_o, 1);
    next_cycle(); core_req(1, 10'h051, 32'h12345678, 4'b0011, 0);
    sample();
    check("t3_core_yumi", bus.core_yumi_o, 1);
    check("t3_dmem_w", bus.dmem_w_o, 1);
    check("t3_dmem_data", bus.dmem_data_o, 32'h12345678);
    check("t3_dmem_mask", bus.dmem_mask_o, 32'h3);
    check("t3_net_rdata_v", bus.net_rdata_v_o, 1);
    check("t3_core_rdata_v", bus.core_rdata_v_o, 0);
    next_cycle(); core_req(0, 10'h051, 0, 0, 0); expect_rsp(0, 32'hC0DE5678);
    sample();

    // LR to 0x020; store to 0x021 keeps it, store to 0x020 breaks it.
    next_cycle(); core_req(0, 10'h020, 0, 0, 1); expect_rsp(0, 32'hC0DE0020);
    sample();
    next_cycle(); net_req(1, 10'h021, 32'hAA, 4'b0001);
    sample();
    check("t4_reserved_set", bus.reserved_o, 1);
    check("t4_reserved_addr", bus.reserved_addr_o, 32'h020);
    check("t4_net_store_yumi", bus.net_yumi_o, 1);
    next_cycle(); net_req(1, 10'h020, 32'hBB, 4'b0001);
    sample();
    check("t4_neighbor_keeps", bus.reserved_o, 1);
    check("t4_neighbor_no_break", bus.reserve_break_o, 0);
    next_cycle(); sample();
    check("t4_break_pulse", bus.reserve_break_o, 1);
    check("t4_reserved_clr", bus.reserved_o, 0);
    next_cycle(); sample();
    check("t4_break_one_cycle", bus.reserve_break_o, 0);
    check("t4_reserved_stays_clr", bus.reserved_o, 0);

    // Reserve on a store is ignored; a zero-mask store still breaks.
    next_cycle(); core_req(1, 10'h060, 0, 0, 1);
    sample();
    next_cycle(); sample();
    check("t4_store_reserve_ignored", bus.reserved_o, 0);
    next_cycle(); core_req(0, 10'h022, 0, 0, 1); expect_rsp(0, 32'hC0DE0022);
    sample();
    next_cycle(); core_req(1, 10'h022, 32'h0, 4'b0000, 0);
    sample();
    check("t4_lr2_reserved", bus.reserved_o, 1);
    next_cycle(); sample();
    check("t4_mask0_break", bus.reserve_break_o, 1);
    check("t4_mask0_reserved_clr", bus.reserved_o, 0);

    // A newer LR moves the reservation; a store to the old word does nothing.
    next_cycle(); core_req(0, 10'h030, 0, 0, 1); expect_rsp(0, 32'hC0DE0030);
    sample();
    next_cycle(); core_req(0, 10'h040, 0, 0, 1); expect_rsp(0, 32'hC0DE0040);
    sample();
    check("t5_addr_first", bus.reserved_addr_o, 32'h030);
    next_cycle(); core_req(1, 10'h030, 32'h5555, 4'hF, 0);
    sample();
    check("t5_addr_moved", bus.reserved_addr_o, 32'h040);
    next_cycle(); sample();
    check("t5_no_break", bus.reserve_break_o, 0);
    check("t5_still_reserved", bus.reserved_o, 1);

    // Async reset right after a granted net read drops the response.
    next_cycle(); net_req(0, 10'h012, 0, 0);
    sample();
    check("t6_net_yumi", bus.net_yumi_o, 1);
    next_cycle();
    check("t6_rdata_v_before_rst", bus.net_rdata_v_o, 1);
    #2 rst_n = 0;
    #1;
    check("t6_rst_net_rdata_v", bus.net_rdata_v_o, 0);
    check("t6_rst_net_rdata", bus.net_rdata_o, 0);
    check("t6_rst_reserved", bus.reserved_o, 0);
    check("t6_rst_reserved_addr", bus.reserved_addr_o, 0);
    check("t6_rst_break", bus.reserve_break_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      core_req(1, 10'(10'h070 + i), 32'(i), 4'hF, 0);
      net_req(1, 10'(10'h080 + i), 32'(i), 4'hF);
      sample();
      check($sformatf("t6_core_yumi_%0d", i), bus.core_yumi_o, (i != 4));
      check($sformatf("t6_net_yumi_%0d", i), bus.net_yumi_o, (i == 4));
    end

    repeat (3) next_cycle();
    check("rsp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Sequences the tile's single-port local DMEM between two requesters:
  - core load/store unit requests (local-DMEM decoded accesses);
  - incoming network endpoint requests (remote loads/stores targeting this tile's DMEM).
- Grants at most one access per cycle and returns read data one cycle later to the requester that issued the read.
- Tracks the single load-reserved (LR) reservation, which is broken by any store to the reserved word.

Parameters:
- data_width_p, 32, data word width; must be 32.
- dmem_size_p, 1024, DMEM depth in words.
- starve_limit_p, 4, consecutive cycles the network may be denied before it gets forced priority; valid range 1..15.
- dmem_addr_width_lp, clog2(dmem_size_p), localparam, word address width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- core_v_i  in  1  core request valid.
- core_w_i  in  1  core store (1) / load (0).
- core_addr_i  in  dmem_addr_width_lp  core word address.
- core_data_i  in  32  core store data.
- core_mask_i  in  4  core byte mask.
- core_reserve_i  in  1  core load is LR; sets the reservation.
- core_yumi_o  out  1  core request accepted this cycle.
- core_rdata_v_o  out  1  core read data valid.
- core_rdata_o  out  32  core read data.
- net_v_i  in  1  network request valid.
- net_w_i  in  1  network store (1) / load (0).
- net_addr_i  in  dmem_addr_width_lp  network word address.
- net_data_i  in  32  network store data.
- net_mask_i  in  4  network byte mask.
- net_yumi_o  out  1  network request accepted this cycle.
- net_rdata_v_o  out  1  network read data valid.
- net_rdata_o  out  32  network read data.
- dmem_v_o  out  1  DMEM access enable.
- dmem_w_o  out  1  DMEM write enable.
- dmem_addr_o  out  dmem_addr_width_lp  DMEM address.
- dmem_data_o  out  32  DMEM write data.
- dmem_mask_o  out  4  DMEM byte mask.
- dmem_data_i  in  32  DMEM read data, valid the cycle after a read.
- reserved_o  out  1  reservation valid.
- reserved_addr_o  out  dmem_addr_width_lp  reserved word address.
- reserve_break_o  out  1  one-cycle pulse when a valid reservation is cleared by a store.

Behaviour:
- Grant logic is combinational within the cycle. Yumis depend on the _v inputs and registered state only, never on each other's outputs.
- Default priority is core:
  - core_yumi_o = core_v_i & ~force_net;
  - net_yumi_o = net_v_i & (~core_v_i | force_net).
- force_net = (starve_cnt_r >= starve_limit_p).
- starve_cnt_r (4 bits):
  - reset 0;
  - +1 on cycles with net_v_i & ~net_yumi_o, saturating at 15;
  - cleared to 0 on any net grant;
  - holds when net_v_i = 0.
- DMEM outputs mux the granted requester. dmem_v_o = core_yumi_o | net_yumi_o. When neither is granted, dmem_w_o, dmem_addr_o, dmem_data_o and dmem_mask_o are 0.
- Read return, fixed 1-cycle latency:
  - rd_owner_r records {core, net, none} for the granted read;
  - next cycle, the matching *_rdata_v_o = 1 and *_rdata_o = dmem_data_i;
  - the non-owner rdata outputs are 0;
  - stores produce no response.
- Reservation:
  - Core granted load with core_reserve_i: reserved_o <= 1 and reserved_addr_o <= core_addr_i. A new LR overwrites the address.
  - Granted store (core or net) with addr == reserved_addr_o while reserved_o = 1: reserved_o <= 0 next cycle, and reserve_break_o pulses in that same next cycle.
  - Any mask value, including 0, counts as a store.
  - core_reserve_i with core_w_i = 1 is ignored.
- Only one grant occurs per cycle, so a set and a break never coincide.
- Reset (asynchronous, any cycle):
  - all registers cleared: starve_cnt_r = 0, rd_owner_r = none, reserved_o = 0, reserved_addr_o = 0, reserve_break_o = 0;
  - all registered outputs go 0 immediately;
  - an in-flight read response is dropped with no rdata_v;
  - a request pending at reset deassertion is arbitrated fresh.
- Illegal condition (assertion): both yumis high in the same cycle.

Test Plan:
- Core-only load to addr 0x010, DMEM returns 0xDEADBEEF -> core_yumi_o = 1 in cycle 0; core_rdata_v_o = 1 and core_rdata_o = 0xDEADBEEF in cycle 1; net outputs stay 0.
- Core and net both continuously valid, starve_limit_p = 4 -> core granted cycles 0-3, net granted cycle 4, counter resets, and the pattern repeats with 1 net grant per 5 cycles.
- Net load in cycle 0 then core store in cycle 1 -> net_rdata_v_o = 1 in cycle 1 alongside the core store grant; core_rdata_v_o stays 0.
- Core LR to 0x020, then net store to 0x020 with mask 4'b0001 -> reserved_o = 1 and reserved_addr_o = 0x020; reserve_break_o pulses the cycle after the store; reserved_o = 0 thereafter. A net store to 0x021 instead leaves the reservation intact.
- Core LR to 0x030, then core LR to 0x040, then store to 0x030 -> reservation address becomes 0x040; no break occurs.
- Assert reset_n_i low asynchronously mid-cycle after a granted net read -> outputs clear before the next edge; no net_rdata_v_o; starve_cnt_r = 0 after release.
